// File: rtl/sd_cmd_pkg.sv
// Shared types, constants and the CRC7 step function for the SD command transmitter.
// The CRC step is kept here so the accumulator and any future users agree on bit order.
package sd_cmd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ARMED = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam int         FRAME_BYTES = 6;
    localparam int         DATA_BITS   = 40;
    localparam logic [6:0] CRC7_POLY   = 7'h09;

    // One serial CRC7 step, MSB-first data; poly excludes the implicit x^7 term.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc,
                                             input logic       din,
                                             input logic [6:0] poly);
        return {crc[5:0], 1'b0} ^ ((crc[6] ^ din) ? poly : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: clears on clr, absorbs one data bit per en.
module sd_crc7
    import sd_cmd_pkg::*;
#(
    parameter logic [6:0] POLY = CRC7_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 7'h00;
        end else if (clr) begin
            crc_q <= 7'h00;
        end else if (en) begin
            crc_q <= crc7_step(crc_q, din, POLY);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line frame serialiser driven by the bit timer's load/shift strobes.
// Frame: start 0, tx 1, 6-bit index, 32-bit argument, CRC7, end bit; MSB first.
module sd_cmd_tx
    import sd_cmd_pkg::*;
#(
    parameter logic [6:0] CRC_POLY = CRC7_POLY,
    parameter logic       END_BIT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        load_enable,
    input  logic        shift_enable,
    output logic        sending,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);
    localparam logic [3:0] BYTE_END  = 4'd8;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] frame_q, frame_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           byte_cnt_q, byte_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 err_q, err_d;

    logic       crc_clr;
    logic       crc_en;
    logic [6:0] crc_val;
    logic       load_ok;
    logic       shift_ok;
    logic [7:0] next_byte;

    sd_crc7 #(
        .POLY(CRC_POLY)
    ) u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (shreg_q[7]),
        .crc (crc_val)
    );

    // A load is only legal at a byte boundary; a coincident shift is always dropped.
    assign load_ok  = load_enable && (bit_cnt_q == BYTE_END);
    assign shift_ok = shift_enable && !load_enable && (bit_cnt_q != BYTE_END);

    always_comb begin
        next_byte = {crc_val, END_BIT};
        case (byte_cnt_q)
            3'd1:    next_byte = frame_q[31:24];
            3'd2:    next_byte = frame_q[23:16];
            3'd3:    next_byte = frame_q[15:8];
            3'd4:    next_byte = frame_q[7:0];
            default: next_byte = {crc_val, END_BIT};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        err_d      = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_d    = {1'b0, 1'b1, cmd_index, cmd_arg};
                    crc_clr    = 1'b1;
                    byte_cnt_d = 3'd0;
                    bit_cnt_d  = 4'd0;
                    state_d    = ARMED;
                end
            end

            ARMED: begin
                err_d = shift_enable;
                if (load_enable) begin
                    shreg_d   = frame_q[39:32];
                    bit_cnt_d = 4'd0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                err_d = (load_enable && !load_ok) || (shift_enable && !shift_ok);
                if (load_ok) begin
                    shreg_d   = next_byte;
                    bit_cnt_d = 4'd0;
                end else if (shift_ok) begin
                    crc_en    = (byte_cnt_q < LAST_BYTE);
                    shreg_d   = {shreg_q[6:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d = DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            shreg_q    <= 8'hFF;
            byte_cnt_q <= 3'd0;
            bit_cnt_q  <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            err_q      <= err_d;
        end
    end

    assign sending = (state_q == ARMED) || (state_q == SHIFT);
    assign cmd_oe  = (state_q == SHIFT);
    assign cmd_out = (state_q == SHIFT) ? shreg_q[7] : 1'b1;
    assign done    = (state_q == DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: timer-style strobes with random gaps,
// frames compared against a polynomial-division model of the SD command frame.
module tb_sd_cmd_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        load_enable;
    logic        shift_enable;
    logic        sending;
    logic        cmd_out;
    logic        cmd_oe;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    int done_seen = 0;

    logic [47:0] obs_bits;
    int          ctl_bad;
    logic        done_at_end;
    logic        done_after;
    logic        sending_after;
    int          err_delta;
    int          done_delta;

    always #5 clk = ~clk;

    sd_cmd_tx dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .sending      (sending),
        .cmd_out      (cmd_out),
        .cmd_oe       (cmd_oe),
        .done         (done),
        .err          (err)
    );

    always @(negedge clk) begin
        if (err === 1'b1) err_seen++;
        if (done === 1'b1) done_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "timeout");
    end

    // Reference: CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] r;
        logic [46:0] g;
        m = {2'b01, idx, arg};
        r = {m, 7'b0};
        g = 47'h89;
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (g << (i - 7));
        end
        return {m, r[6:0], 1'b1};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(2, 0);
        repeat (n) begin
            tick();
            if (sending !== 1'b1) ctl_bad++;
        end
    endtask

    task automatic do_start(input logic [5:0] idx, input logic [31:0] arg);
        cmd_index = idx;
        cmd_arg   = arg;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
    endtask

    task automatic do_load();
        gap();
        load_enable = 1'b1;
        tick();
        load_enable = 1'b0;
        if (sending !== 1'b1) ctl_bad++;
    endtask

    task automatic do_shift();
        gap();
        obs_bits = {obs_bits[46:0], cmd_out};
        if (cmd_oe !== 1'b1 || sending !== 1'b1) ctl_bad++;
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
    endtask

    // mode 0: clean; 1: early shift + mid-byte load; 2: mid-frame start + coincident load/shift.
    task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input int mode);
        int e0;
        int d0;
        obs_bits = '0;
        ctl_bad  = 0;
        e0 = err_seen;
        d0 = done_seen;
        do_start(idx, arg);
        if (sending !== 1'b1) ctl_bad++;
        if (mode == 1) begin
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
        end
        for (int b = 0; b < 6; b++) begin
            if (mode == 2 && b == 2) begin
                load_enable  = 1'b1;
                shift_enable = 1'b1;
                tick();
                load_enable  = 1'b0;
                shift_enable = 1'b0;
            end else begin
                do_load();
            end
            for (int k = 0; k < 8; k++) begin
                if (mode == 1 && b == 1 && k == 3) begin
                    load_enable = 1'b1;
                    tick();
                    load_enable = 1'b0;
                end
                if (mode == 2 && b == 0 && k == 4) begin
                    cmd_index = 6'h3F;
                    cmd_arg   = 32'hFFFF_FFFF;
                    start     = 1'b1;
                    tick();
                    start     = 1'b0;
                end
                do_shift();
            end
        end
        done_at_end = done;
        tick();
        done_after    = done;
        sending_after = sending;
        tick();
        tick();
        err_delta  = err_seen - e0;
        done_delta = done_seen - d0;
        $display("[TB] frame mode=%0d idx=%0d arg=%08h got=%012h exp=%012h errs=%0d",
                 mode, idx, arg, obs_bits, model_frame(idx, arg), err_delta);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; load_enable = 1'b0; shift_enable = 1'b0;
        cmd_index = '0; cmd_arg = '0;
        tick(); tick();
        tests++; if (sending !== 1'b0) begin fails++; $display("FAIL reset_sending got=%b exp=0", sending); end
        tests++; if (cmd_out !== 1'b1) begin fails++; $display("FAIL reset_cmd_out got=%b exp=1", cmd_out); end
        tests++; if (cmd_oe !== 1'b0)  begin fails++; $display("FAIL reset_cmd_oe got=%b exp=0", cmd_oe); end
        tests++; if (done !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL reset_done_err got=%b%b exp=00", done, err);
        end
        rst = 1'b0;
        tick();
        $display("[TB] reset released");
    endtask

    task automatic test_fixed_vectors();
        logic [5:0]  idx_v [3];
        logic [31:0] arg_v [3];
        logic [47:0] exp_v [3];
        idx_v[0] = 6'd0;  arg_v[0] = 32'h0;        exp_v[0] = 48'h40_00_00_00_00_95;
        idx_v[1] = 6'd17; arg_v[1] = 32'h0;        exp_v[1] = 48'h51_00_00_00_00_55;
        idx_v[2] = 6'd8;  arg_v[2] = 32'h000001AA; exp_v[2] = 48'h48_00_00_01_AA_87;
        for (int i = 0; i < 3; i++) begin
            run_frame(idx_v[i], arg_v[i], 0);
            tests++; if (obs_bits !== exp_v[i]) begin
                fails++; $display("FAIL fixed_bits[%0d] got=%012h exp=%012h", i, obs_bits, exp_v[i]);
            end
            tests++; if (done_at_end !== 1'b1 || done_after !== 1'b0 || done_delta != 1) begin
                fails++; $display("FAIL fixed_done[%0d] got=%b%b/%0d exp=10/1", i, done_at_end, done_after, done_delta);
            end
            tests++; if (ctl_bad != 0 || sending_after !== 1'b0 || err_delta != 0) begin
                fails++; $display("FAIL fixed_ctl[%0d] got bad=%0d snd=%b err=%0d exp 0/0/0", i, ctl_bad, sending_after, err_delta);
            end
        end
    endtask

    task automatic test_random_frames();
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] exp_bits;
        for (int i = 0; i < 5; i++) begin
            idx = 6'($urandom);
            arg = $urandom;
            exp_bits = model_frame(idx, arg);
            run_frame(idx, arg, 0);
            tests++; if (obs_bits !== exp_bits) begin
                fails++; $display("FAIL rand_bits[%0d] got=%012h exp=%012h", i, obs_bits, exp_bits);
            end
            tests++; if (done_at_end !== 1'b1 || done_after !== 1'b0 || done_delta != 1) begin
                fails++; $display("FAIL rand_done[%0d] got=%b%b/%0d exp=10/1", i, done_at_end, done_after, done_delta);
            end
            tests++; if (ctl_bad != 0 || err_delta != 0) begin
                fails++; $display("FAIL rand_ctl[%0d] got bad=%0d err=%0d exp 0/0", i, ctl_bad, err_delta);
            end
        end
    endtask

    task automatic test_protocol_errors();
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] exp_bits;
        idx = 6'($urandom);
        arg = $urandom;
        exp_bits = model_frame(idx, arg);
        run_frame(idx, arg, 1);
        tests++; if (err_delta != 2) begin
            fails++; $display("FAIL proto_err_count got=%0d exp=2", err_delta);
        end
        tests++; if (obs_bits !== exp_bits || done_delta != 1) begin
            fails++; $display("FAIL proto_frame got=%012h/%0d exp=%012h/1", obs_bits, done_delta, exp_bits);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] exp_bits;
        idx = 6'($urandom);
        arg = $urandom;
        exp_bits = model_frame(idx, arg);
        run_frame(idx, arg, 2);
        tests++; if (err_delta != 1) begin
            fails++; $display("FAIL coincident_err_count got=%0d exp=1", err_delta);
        end
        tests++; if (obs_bits !== exp_bits) begin
            fails++; $display("FAIL coincident_bits got=%012h exp=%012h", obs_bits, exp_bits);
        end
        tests++; if (done_at_end !== 1'b1 || done_delta != 1) begin
            fails++; $display("FAIL coincident_done got=%b/%0d exp=1/1", done_at_end, done_delta);
        end
    endtask

    task automatic test_reset_abort();
        int          d0;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] exp_bits;
        obs_bits = '0;
        ctl_bad  = 0;
        do_start(6'($urandom), $urandom);
        for (int b = 0; b < 3; b++) begin
            do_load();
            for (int k = 0; k < ((b == 2) ? 4 : 8); k++) do_shift();
        end
        d0 = done_seen;
        rst = 1'b1;
        #1;
        tests++; if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || sending !== 1'b0) begin
            fails++; $display("FAIL abort_outputs got oe=%b out=%b snd=%b exp 0/1/0", cmd_oe, cmd_out, sending);
        end
        tick();
        rst = 1'b0;
        repeat (10) tick();
        tests++; if (done_seen != d0 || sending !== 1'b0) begin
            fails++; $display("FAIL abort_no_done got=%0d snd=%b exp=0/0", done_seen - d0, sending);
        end
        $display("[TB] reset abort after 20 shifts");
        idx = 6'($urandom);
        arg = $urandom;
        exp_bits = model_frame(idx, arg);
        run_frame(idx, arg, 0);
        tests++; if (obs_bits !== exp_bits || done_delta != 1 || err_delta != 0) begin
            fails++; $display("FAIL abort_refill got=%012h/%0d/%0d exp=%012h/1/0", obs_bits, done_delta, err_delta, exp_bits);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_vectors();
        test_random_frames();
        test_protocol_errors();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
